// File: rtl/fetch_hazard_ctrl.sv
// Front-end hazard scheduler: stalls IF/ID and bubbles EX on load-use, branch-operand and HI/LO busy hazards.
// Optional stall-cycle counter enabled by HAZ_PERF_CNT_EN.
module fetch_hazard_ctrl #(
  parameter int unsigned MD_CYCLES  = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_md_start,
  input  logic                  id_uses_hilo,
  input  logic                  ex_wr_en,
  input  logic [REG_ADDR_W-1:0] ex_wr_addr,
  input  logic                  ex_mem_read,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_wr_addr,
  output logic                  if_stall,
  output logic                  id_stall,
  output logic                  ex_flush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [31:0]           perf_stall_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [7:0] MD_RELOAD = 8'(MD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;

  logic ex_match, mem_match;
  logic load_use, br_haz, hilo_haz, md_finishing, haz, accept;

  assign ex_match  = (ex_wr_addr != '0) &&
                     ((id_uses_rs && id_rs == ex_wr_addr) || (id_uses_rt && id_rt == ex_wr_addr));
  assign mem_match = (mem_wr_addr != '0) &&
                     ((id_uses_rs && id_rs == mem_wr_addr) || (id_uses_rt && id_rt == mem_wr_addr));

  assign load_use     = ex_mem_read && ex_match;
  assign br_haz       = id_is_branch && ((ex_wr_en && ex_match) || (mem_mem_read && mem_match));
  assign md_finishing = (state_q == MD_BUSY) && (md_cnt_q == 8'd0);
  assign hilo_haz     = id_uses_hilo && (state_q == MD_BUSY) && !md_finishing;
  assign haz          = load_use || br_haz || hilo_haz;
  // A MULT/DIV stalled behind another hazard is simply re-presented later.
  assign accept       = id_md_start && !haz;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if_stall = 1'b0;
    id_stall = 1'b0;
    ex_flush = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_RELOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q != 8'd0) begin
          md_cnt_d = md_cnt_q - 8'd1;
        end else if (accept) begin
          md_cnt_d = MD_RELOAD;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      if_stall = haz;
      id_stall = haz;
      ex_flush = haz;
      md_busy  = (state_q == MD_BUSY);
      md_done  = md_finishing;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_q <= 32'd0;
    end else if (haz && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_fetch_hazard_ctrl;
  localparam int MDC = 4;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr_addr, mem_wr_addr;
  logic       id_uses_rs, id_uses_rt, id_is_branch, id_md_start, id_uses_hilo;
  logic       ex_wr_en, ex_mem_read, mem_mem_read;
  logic       if_stall, id_stall, ex_flush, md_busy, md_done;
  logic [31:0] perf_stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: cycles of MULT/DIV occupancy left (0 = idle, 1 = completing now).
  int          m_left = 0;
  logic [31:0] m_perf = 0;

  fetch_hazard_ctrl #(.MD_CYCLES(MDC), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_md_start(id_md_start), .id_uses_hilo(id_uses_hilo),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_mem_read(ex_mem_read),
    .mem_mem_read(mem_mem_read), .mem_wr_addr(mem_wr_addr),
    .if_stall(if_stall), .id_stall(id_stall), .ex_flush(ex_flush),
    .md_busy(md_busy), .md_done(md_done), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic reads_reg(input logic [4:0] a);
    return (a != 0) && ((id_uses_rs && id_rs == a) || (id_uses_rt && id_rt == a));
  endfunction

  function automatic logic m_haz();
    logic lu, br, hl;
    lu = ex_mem_read && reads_reg(ex_wr_addr);
    br = id_is_branch && ((ex_wr_en && reads_reg(ex_wr_addr)) ||
                          (mem_mem_read && reads_reg(mem_wr_addr)));
    hl = id_uses_hilo && (m_left > 1);
    return rst && (lu || br || hl);
  endfunction

  function automatic logic [31:0] exp_perf();
`ifdef HAZ_PERF_CNT_EN
    return m_perf;
`else
    return 32'h0;
`endif
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
    id_md_start = 0; id_uses_hilo = 0; ex_wr_en = 0; ex_wr_addr = 0;
    ex_mem_read = 0; mem_mem_read = 0; mem_wr_addr = 0;
  endtask

  // Advance one clock, updating the model with the inputs held across the edge.
  task automatic tick();
    logic h;
    h = m_haz();
    @(posedge clk);
    if (!rst) begin
      m_left = 0;
      m_perf = 0;
    end else begin
      if (h && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (id_md_start && !h && m_left <= 1) m_left = MDC;
      else if (m_left > 0) m_left = m_left - 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    ex_mem_read = 1; ex_wr_addr = 8; id_rs = 8; id_uses_rs = 1; id_uses_hilo = 1;
    tick(); tick();
    #1;
    n_total++;
    if ({if_stall, id_stall, ex_flush, md_busy, md_done} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {if_stall, id_stall, ex_flush, md_busy, md_done});
    else n_pass++;
    n_total++;
    if (perf_stall_cnt !== 32'h0) $display("FAIL reset_perf: got %0d want 0", perf_stall_cnt);
    else n_pass++;
    idle_inputs();
    rst = 1;
    tick();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_wr_addr = 8; id_rs = 8; id_uses_rs = 1;
    #1;
    n_total++;
    if ({if_stall, id_stall, ex_flush} !== 3'b111)
      $display("FAIL load_use_stall: got %b want 111", {if_stall, id_stall, ex_flush});
    else n_pass++;
    tick();
    ex_mem_read = 0; ex_wr_addr = 0;
    #1;
    n_total++;
    if ({if_stall, id_stall, ex_flush} !== 3'b000)
      $display("FAIL load_use_bubble: got %b want 000", {if_stall, id_stall, ex_flush});
    else n_pass++;
    tick();
    ex_mem_read = 1; ex_wr_addr = 0; id_rs = 0;
    #1;
    n_total++;
    if (if_stall !== 1'b0) $display("FAIL load_use_r0: got %b want 0", if_stall);
    else n_pass++;
    ex_wr_addr = 8; id_rs = 8; id_uses_rs = 0;
    #1;
    n_total++;
    if (if_stall !== 1'b0) $display("FAIL load_use_unused_rs: got %b want 0", if_stall);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_branch();
    int stalls;
    id_is_branch = 1; id_rt = 9; id_uses_rt = 1; ex_wr_en = 1; ex_wr_addr = 9;
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (if_stall === 1'b1) stalls++;
      tick();
      ex_wr_en = 0; ex_wr_addr = 0; mem_mem_read = 0; mem_wr_addr = 9;
    end
    n_total++;
    if (stalls != 1) $display("FAIL branch_alu_stalls: got %0d want 1", stalls);
    else n_pass++;
    idle_inputs();
    tick();
    id_is_branch = 1; id_rt = 9; id_uses_rt = 1;
    ex_wr_en = 1; ex_mem_read = 1; ex_wr_addr = 9;
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (if_stall === 1'b1) stalls++;
      tick();
      ex_wr_en = 0; ex_mem_read = 0; ex_wr_addr = 0;
      mem_mem_read = (c == 0); mem_wr_addr = (c == 0) ? 5'd9 : 5'd0;
    end
    n_total++;
    if (stalls != 2) $display("FAIL branch_load_stalls: got %0d want 2", stalls);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_md();
    id_md_start = 1;
    #1;
    n_total++;
    if (md_busy !== 1'b0) $display("FAIL md_idle_busy: got %b want 0", md_busy);
    else n_pass++;
    tick();
    id_md_start = 0; id_uses_hilo = 1;
    for (int k = 1; k <= MDC; k++) begin
      #1;
      n_total++;
      if ({md_busy, md_done, if_stall} !== {1'b1, k == MDC, k < MDC})
        $display("FAIL md_cycle%0d: busy/done/stall got %b want %b", k,
                 {md_busy, md_done, if_stall}, {1'b1, k == MDC, k < MDC});
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({md_busy, if_stall} !== 2'b00) $display("FAIL md_after: got %b want 00", {md_busy, if_stall});
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    id_md_start = 1; id_uses_hilo = 1;
    tick();
    id_md_start = 0; id_uses_hilo = 0;
    tick(); tick(); tick();
    id_md_start = 1; id_uses_hilo = 1;
    #1;
    n_total++;
    if ({md_done, if_stall} !== 2'b10) $display("FAIL b2b_done_cycle: done/stall got %b want 10", {md_done, if_stall});
    else n_pass++;
    tick();
    id_md_start = 0; id_uses_hilo = 0;
    for (int k = 1; k <= MDC; k++) begin
      #1;
      n_total++;
      if ({md_busy, md_done} !== {1'b1, k == MDC})
        $display("FAIL b2b_cycle%0d: busy/done got %b want %b", k, {md_busy, md_done}, {1'b1, k == MDC});
      else n_pass++;
      tick();
    end
    id_md_start = 1; id_uses_hilo = 1; ex_mem_read = 1; ex_wr_addr = 3; id_rs = 3; id_uses_rs = 1;
    #1;
    n_total++;
    if (if_stall !== 1'b1) $display("FAIL b2b_blocked_stall: got %b want 1", if_stall);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (md_busy !== 1'b0) $display("FAIL b2b_blocked_busy: got %b want 0", md_busy);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    id_md_start = 1;
    tick();
    id_md_start = 0;
    tick();
    rst = 0; id_uses_hilo = 1;
    #1;
    n_total++;
    if ({if_stall, md_busy, md_done} !== 3'b000)
      $display("FAIL reset_mid_forced: got %b want 000", {if_stall, md_busy, md_done});
    else n_pass++;
    tick();
    rst = 1;
    #1;
    n_total++;
    if ({md_busy, if_stall} !== 2'b00) $display("FAIL reset_mid_release: busy/stall got %b want 00", {md_busy, if_stall});
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_perf();
    rst = 0;
    tick();
    rst = 1;
    ex_mem_read = 1; ex_wr_addr = 8; id_rs = 8; id_uses_rs = 1;
    tick();
    idle_inputs();
    id_is_branch = 1; id_rt = 9; id_uses_rt = 1; ex_wr_en = 1; ex_mem_read = 1; ex_wr_addr = 9;
    tick();
    ex_wr_en = 0; ex_mem_read = 0; ex_wr_addr = 0; mem_mem_read = 1; mem_wr_addr = 9;
    tick();
    idle_inputs();
    tick();
    #1;
    n_total++;
`ifdef HAZ_PERF_CNT_EN
    if (perf_stall_cnt !== 32'd3) $display("FAIL perf_three: got %0d want 3", perf_stall_cnt);
    else n_pass++;
`else
    if (perf_stall_cnt !== 32'd0) $display("FAIL perf_disabled: got %0d want 0", perf_stall_cnt);
    else n_pass++;
`endif
    rst = 0;
    tick();
    rst = 1;
    #1;
    n_total++;
    if (perf_stall_cnt !== 32'd0) $display("FAIL perf_reset: got %0d want 0", perf_stall_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    logic [4:0] exp;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 39) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_is_branch = ($urandom_range(0, 3) == 0);
      id_md_start  = ($urandom_range(0, 5) == 0);
      id_uses_hilo = id_md_start || ($urandom_range(0, 2) == 0);
      ex_wr_en     = 1'($urandom);
      ex_mem_read  = ex_wr_en && ($urandom_range(0, 2) == 0);
      ex_wr_addr   = 5'($urandom_range(0, 3));
      mem_mem_read = ($urandom_range(0, 2) == 0);
      mem_wr_addr  = 5'($urandom_range(0, 3));
      #1;
      exp = {m_haz(), m_haz(), m_haz(), rst && m_left > 0, rst && m_left == 1};
      n_total++;
      if ({if_stall, id_stall, ex_flush, md_busy, md_done} !== exp || perf_stall_cnt !== exp_perf()) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d: stall3/busy/done got %b want %b, perf got %0d want %0d", c,
                   {if_stall, id_stall, ex_flush, md_busy, md_done}, exp, perf_stall_cnt, exp_perf());
        errs++;
      end else n_pass++;
      tick();
    end
    idle_inputs();
    rst = 1;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_md();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
